// File: rtl/majority_frame_collector_if.sv
// ============================================================================
// majority_frame_collector_if : serial-in / frame-out bundle for the collector
// Revision: 1.0
// ============================================================================
`default_nettype none

interface majority_frame_collector_if #(
  parameter int FRAME_W = 12,
  parameter int CNT_W   = 8
);
  logic               s_bit;
  logic               s_valid;
  logic               s_sof;
  logic [FRAME_W-1:0] A;
  logic               a_valid;
  logic               a_ready;
  logic               drop;
  logic               par_err;
  logic [CNT_W-1:0]   drop_cnt;

  modport master (
    output s_bit, s_valid, s_sof, a_ready,
    input  A, a_valid, drop, par_err, drop_cnt
  );

  modport slave (
    input  s_bit, s_valid, s_sof, a_ready,
    output A, a_valid, drop, par_err, drop_cnt
  );
endinterface

`default_nettype wire

// File: rtl/majority_frame_collector.sv
// ============================================================================
// majority_frame_collector : framed serial bits -> double-buffered word on A.
// Optional even-parity bit per frame enabled by MAJORITY_PARITY_CHECK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module majority_frame_collector #(
  parameter int FRAME_W = 12,
  parameter int CNT_W   = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  majority_frame_collector_if.slave   bus
);

  localparam int BIT_CNT_W = $clog2(FRAME_W + 1);
  localparam logic [BIT_CNT_W-1:0] LAST_CNT = BIT_CNT_W'(FRAME_W - 1);

`ifdef MAJORITY_PARITY_CHECK_EN
  localparam int SHIFT_W = FRAME_W;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    PARITY  = 2'd2
  } state_t;
`else
  // The final data bit is taken straight from s_bit, so one fewer stage is stored.
  localparam int SHIFT_W = FRAME_W - 1;
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1
  } state_t;
`endif

  state_t               state_q;
  logic [SHIFT_W-1:0]   shift_q;
  logic [SHIFT_W-1:0]   shift_d;
  logic [BIT_CNT_W-1:0] bit_cnt_q;
  logic [FRAME_W-1:0]   a_q;
  logic                 a_valid_q;
  logic                 drop_q;
  logic [CNT_W-1:0]     drop_cnt_q;
  logic                 frame_done;
  logic [FRAME_W-1:0]   frame_data;
`ifdef MAJORITY_PARITY_CHECK_EN
  logic                 par_fail;
  logic                 par_err_q;
`endif

  always_comb begin
    shift_d    = {shift_q[SHIFT_W-2:0], bus.s_bit};
    frame_done = 1'b0;
`ifdef MAJORITY_PARITY_CHECK_EN
    frame_data = shift_q;
    par_fail   = 1'b0;
    if (bus.s_valid && !bus.s_sof && state_q == PARITY) begin
      if (^{shift_q, bus.s_bit}) begin
        par_fail = 1'b1;
      end else begin
        frame_done = 1'b1;
      end
    end
`else
    frame_data = {shift_q, bus.s_bit};
    if (bus.s_valid && !bus.s_sof && state_q == COLLECT && bit_cnt_q == LAST_CNT) begin
      frame_done = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      a_q        <= '0;
      a_valid_q  <= 1'b0;
      drop_q     <= 1'b0;
      drop_cnt_q <= '0;
`ifdef MAJORITY_PARITY_CHECK_EN
      par_err_q  <= 1'b0;
`endif
    end else begin
      drop_q <= 1'b0;
`ifdef MAJORITY_PARITY_CHECK_EN
      par_err_q <= par_fail;
`endif
      if (a_valid_q && bus.a_ready) begin
        a_valid_q <= 1'b0;
      end
      // A frame completing while the output is freed this cycle still lands.
      if (frame_done) begin
        if (!a_valid_q || bus.a_ready) begin
          a_q       <= frame_data;
          a_valid_q <= 1'b1;
        end else begin
          drop_q <= 1'b1;
          if (drop_cnt_q != '1) begin
            drop_cnt_q <= drop_cnt_q + CNT_W'(1);
          end
        end
      end

      if (bus.s_valid) begin
        if (bus.s_sof) begin
          shift_q   <= {{(SHIFT_W-1){1'b0}}, bus.s_bit};
          bit_cnt_q <= BIT_CNT_W'(1);
          state_q   <= COLLECT;
        end else begin
          case (state_q)
            IDLE: begin
            end
            COLLECT: begin
              shift_q <= shift_d;
              if (bit_cnt_q == LAST_CNT) begin
`ifdef MAJORITY_PARITY_CHECK_EN
                bit_cnt_q <= BIT_CNT_W'(FRAME_W);
                state_q   <= PARITY;
`else
                bit_cnt_q <= '0;
                state_q   <= IDLE;
`endif
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              end
            end
`ifdef MAJORITY_PARITY_CHECK_EN
            PARITY: begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end
`endif
            default: begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end
          endcase
        end
      end
    end
  end

  assign bus.A        = a_q;
  assign bus.a_valid  = a_valid_q;
  assign bus.drop     = drop_q;
  assign bus.drop_cnt = drop_cnt_q;
`ifdef MAJORITY_PARITY_CHECK_EN
  assign bus.par_err  = par_err_q;
`else
  assign bus.par_err  = 1'b0;
`endif

endmodule

`default_nettype wire

// File: doc/majority_frame_collector.md
# majority_frame_collector

Serial-to-parallel front end for the 12-bit majority voter. Assembles framed serial bits into a 12-bit word and presents it with a valid/ready handshake on output `A`, which drives the voter input. Completed words are double-buffered: one frame is held on the output while the next frame is shifted in. Frames that cannot be delivered are dropped and counted.

## Interface
- `FRAME_W`, 12, data bits per frame and width of `A`.
- `CNT_W`, 8, width of the saturating drop counter.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `s_bit`  in  1  serial data bit.
- `s_valid`  in  1  `s_bit` is accepted this cycle. Bits are always accepted; there is no backpressure.
- `s_sof`  in  1  start of frame; only meaningful when `s_valid`=1.
- `A`  out  FRAME_W  assembled frame for the voter. The first bit received lands in `A[FRAME_W-1]`.
- `a_valid`  out  1  `A` holds a frame.
- `a_ready`  in  1  voter stage accepts `A`.
- `drop`  out  1  one-cycle pulse when a completed frame is discarded.
- `par_err`  out  1  one-cycle pulse when a parity failure occurs (see Configuration).
- `drop_cnt`  out  CNT_W  number of dropped frames; saturates at all-ones.

## Operation
- **State machine states:** IDLE, COLLECT, PARITY. PARITY exists only when the parity feature is compiled in.
- **IDLE:**
  - `s_valid` with `s_sof`=1: load the bit, set `bit_cnt`=1, go to COLLECT.
  - `s_valid` with `s_sof`=0: bit is ignored.
- **COLLECT:** each accepted bit shifts into the shift register and `bit_cnt` increments.
  - If `s_sof`=1 mid-frame: the partial frame is discarded. The current bit becomes bit 1 of a new frame (`bit_cnt`=1). No pulse is generated.
  - On the FRAME_W-th bit:
    - With parity compiled in: go to PARITY.
    - Without parity: the frame is complete; go to IDLE.
- **PARITY:** the next accepted bit is the parity bit.
  - Even parity is required: XOR of the FRAME_W data bits and the parity bit must be 0.
  - Pass: the frame is complete.
  - Fail: pulse `par_err`; the frame is discarded and not counted in `drop_cnt`.
  - Either way, go to IDLE.
  - If `s_sof`=1 on this bit: treat it as a mid-frame restart (as in COLLECT), not as a parity bit.
- **Frame completion:**
  - If the output register is empty, or is being transferred in the same cycle (`a_valid`&`a_ready`): the frame loads into `A` and `a_valid`=1.
  - Otherwise: the frame is discarded, `drop` pulses, and `drop_cnt` increments, saturating.
- **Handshake:**
  - A transfer occurs when `a_valid`&`a_ready` are both 1 on a rising edge.
  - While `a_valid`=1 and `a_ready`=0, `A` and `a_valid` hold stable.
  - `a_valid` falls after a transfer unless a new frame loads in the same cycle.
- **Arithmetic:** `bit_cnt` is ceil(log2(FRAME_W+1)) bits wide, and `drop_cnt` wraps never.

## Timing
- **Reset:** `rst_n`=0 sampled at an edge gives:
  - `A`=0, `a_valid`=0, `drop`=0, `par_err`=0, `drop_cnt`=0.
  - State IDLE, `bit_cnt`=0, shift register cleared.
  - A partial frame or held frame is lost.
- **Latency:** `a_valid` rises on the edge that accepts the last bit (the FRAME_W-th data bit, or the parity bit). `A` is valid in the cycle after that bit is presented.
- **Throughput:** back-to-back frames with `s_valid` held high and `a_ready` held high lose no frames.
- **Pulse timing:** `drop` and `par_err` are registered and asserted for exactly the one cycle following the completing edge.

## Configuration
- **`MAJORITY_PARITY_CHECK_EN` defined:**
  - Frames are FRAME_W data bits plus 1 even-parity bit.
  - PARITY state is present; `par_err` is functional.
- **`MAJORITY_PARITY_CHECK_EN` undefined:**
  - Frames are FRAME_W bits; no PARITY state.
  - `par_err` is tied to 0.

## Test plan
- **Basic frame:** reset, then SOF plus 12 bits 1,1,1,1,1,1,1,0,0,0,0,0 with `a_ready`=1. Expect `A`=12'hFE0 with `a_valid` high for 1 cycle, and `drop`=0.
- **Backpressure/drop:** `a_ready`=0, send three frames 12'hFFF, 12'h000, 12'hAAA.
  - `A` holds 12'hFFF throughout.
  - `drop` pulses twice and `drop_cnt`=2.
  - Raising `a_ready` transfers 12'hFFF, then `a_valid`=0.
- **Simultaneous:** `a_valid`=1 holding 12'h0F0; the last bit of 12'h123 arrives in the same cycle as `a_ready`=1. Expect `A`=12'h123 next cycle, `a_valid` stays 1, no drop.
- **Mid-frame SOF:** 5 bits, then SOF with 12 bits forming 12'h555. Expect `A`=12'h555; the partial frame vanishes silently.
- **Parity (macro defined):** 12'h001 with parity 1 is delivered. 12'h001 with parity 0 gives a `par_err` pulse, `a_valid` stays 0, and `drop_cnt` is unchanged.
- **Reset mid-operation:** `rst_n`=0 after 7 bits while `A` holds a frame. Next cycle all outputs are 0. The following SOF frame 12'hC3C is delivered correctly.
